// File: rtl/sobel_window.sv
// rtl/sobel_window.sv - 3x3 Sobel window with two-stage |Gx|+|Gy| pipeline (option: SOBEL_THRESH_EN)
module sobel_window #(
  parameter int DATA_WIDTH = 12,
  parameter int IMG_WIDTH  = 640
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic                  in_edge,
  input  logic [DATA_WIDTH-1:0] row0_pixel,
  input  logic [DATA_WIDTH-1:0] row1_pixel,
  input  logic [DATA_WIDTH-1:0] row2_pixel,
  input  logic [DATA_WIDTH-1:0] thresh,
  output logic [DATA_WIDTH-1:0] pix_out,
  output logic                  pix_out_valid,
  output logic                  pix_out_edge
);

  localparam int DW = DATA_WIDTH;
  localparam int SW = DW + 2;  // weighted 1-2-1 sum
  localparam int GW = DW + 4;  // signed gradient
  localparam int CW = $clog2(IMG_WIDTH + 1);

  localparam logic [CW-1:0] COL_ONE   = CW'(1);
  localparam logic [CW-1:0] COL_THREE = CW'(3);
  localparam logic [CW-1:0] COL_MAX   = CW'(IMG_WIDTH);
  localparam logic [GW-1:0] MAG_MAX   = {4'b0000, {DW{1'b1}}};

  // win_q[column][row]: column 0 is the oldest (left), row 0 is the bottom row
  logic [DW-1:0] win_q [3][3];
  logic [CW-1:0] col_q, col_d;
  logic          v0_q, e0_q, v1_q, e1_q;
  logic signed [GW-1:0] gx_q, gy_q, gx_d, gy_d;
  logic [SW-1:0] sum_l, sum_r, sum_b, sum_t;
  logic [GW-1:0] abs_x, abs_y, mag;
  logic [DW-1:0] sat_mag, out_d;
  logic          accept, complete, first;

  assign accept = en & in_valid;

  function automatic logic [SW-1:0] wsum(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [DW-1:0] c);
    return SW'(a) + SW'({b, 1'b0}) + SW'(c);
  endfunction

  // Column count: in_edge restarts at 1; a count of 0 means "no line started yet" and stays
  // 0 so that nothing is produced after reset until a line start is seen.
  always_comb begin
    col_d = col_q;
    if (accept) begin
      if (in_edge)
        col_d = COL_ONE;
      else if (col_q != '0 && col_q != COL_MAX)
        col_d = col_q + COL_ONE;
    end
  end

  assign complete = accept && (col_d >= COL_THREE);
  assign first    = accept && (col_d == COL_THREE);

  // Window shift: oldest column drops out, incoming pixels enter as the newest column
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 3; r++)
          win_q[c][r] <= '0;
    end else if (accept) begin
      for (int c = 0; c < 2; c++)
        for (int r = 0; r < 3; r++)
          win_q[c][r] <= win_q[c+1][r];
      win_q[2][0] <= row0_pixel;
      win_q[2][1] <= row1_pixel;
      win_q[2][2] <= row2_pixel;
    end
  end

  // Column counter and the first valid/edge stage of the output pipeline
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= '0;
      v0_q  <= 1'b0;
      e0_q  <= 1'b0;
    end else begin
      col_q <= col_d;
      v0_q  <= complete;
      e0_q  <= first;
    end
  end

  assign sum_l = wsum(win_q[0][2], win_q[0][1], win_q[0][0]);
  assign sum_r = wsum(win_q[2][2], win_q[2][1], win_q[2][0]);
  assign sum_b = wsum(win_q[0][0], win_q[1][0], win_q[2][0]);
  assign sum_t = wsum(win_q[0][2], win_q[1][2], win_q[2][2]);
  assign gx_d  = $signed(GW'(sum_r)) - $signed(GW'(sum_l));
  assign gy_d  = $signed(GW'(sum_b)) - $signed(GW'(sum_t));

  // Stage 1: free-running gradient registers, valid/edge tagged along
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gx_q <= '0;
      gy_q <= '0;
      v1_q <= 1'b0;
      e1_q <= 1'b0;
    end else begin
      gx_q <= gx_d;
      gy_q <= gy_d;
      v1_q <= v0_q;
      e1_q <= e0_q;
    end
  end

  // Each |G| is below 2^(DW+2), so the sum cannot overflow GW bits
  assign abs_x   = gx_q[GW-1] ? -gx_q : gx_q;
  assign abs_y   = gy_q[GW-1] ? -gy_q : gy_q;
  assign mag     = abs_x + abs_y;
  assign sat_mag = (mag > MAG_MAX) ? '1 : mag[DW-1:0];

`ifdef SOBEL_THRESH_EN
  assign out_d = (sat_mag > thresh) ? '1 : '0;
`else
  logic unused_thresh;
  assign unused_thresh = ^thresh;
  assign out_d = sat_mag;
`endif

  // Stage 2: result register only loads on a valid slot so pix_out holds in between
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_out       <= '0;
      pix_out_valid <= 1'b0;
      pix_out_edge  <= 1'b0;
    end else begin
      if (v1_q)
        pix_out <= out_d;
      pix_out_valid <= v1_q;
      pix_out_edge  <= e1_q;
    end
  end

endmodule

// File: tb/tb_sobel_window.sv
// tb/tb_sobel_window.sv - directed table-driven bench for sobel_window
module tb_sobel_window;
  localparam int DW = 12;
  localparam int NV = 38;
  localparam logic [DW-1:0] K8 = 12'h800;
  localparam logic [DW-1:0] KF = 12'hFFF;
  localparam logic [DW-1:0] Z  = 12'h000;
  localparam logic [DW-1:0] T  = 12'd10;
  localparam logic [DW-1:0] M40 = 12'd40;
  localparam logic [DW-1:0] M32 = 12'd32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0, in_valid = 1'b0, in_edge = 1'b0;
  logic [DW-1:0] r0 = '0, r1 = '0, r2 = '0;
  logic [DW-1:0] thresh = 12'd30;
  logic [DW-1:0] pix_out;
  logic          pix_out_valid, pix_out_edge;
  int            pass_cnt = 0;
  int            total_cnt = 0;

  typedef struct packed {
    logic          en;
    logic          vld;
    logic          edg;
    logic [DW-1:0] r0;
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
    logic          ev;
    logic          ee;
    logic [DW-1:0] ep;
  } vec_t;

  vec_t tbl [NV];

  always #5 clk = ~clk;

  sobel_window #(.DATA_WIDTH(DW), .IMG_WIDTH(640)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .in_valid      (in_valid),
    .in_edge       (in_edge),
    .row0_pixel    (r0),
    .row1_pixel    (r1),
    .row2_pixel    (r2),
    .thresh        (thresh),
    .pix_out       (pix_out),
    .pix_out_valid (pix_out_valid),
    .pix_out_edge  (pix_out_edge)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [DW-1:0] xf(input logic [DW-1:0] m);
`ifdef SOBEL_THRESH_EN
    return (m > thresh) ? '1 : '0;
`else
    return m;
`endif
  endfunction

  function automatic vec_t mk(input logic e, input logic v, input logic g, input logic [DW-1:0] a,
                              input logic [DW-1:0] b, input logic [DW-1:0] c, input logic ev,
                              input logic ee, input logic [DW-1:0] ep);
    return '{e, v, g, a, b, c, ev, ee, ep};
  endfunction

  task automatic step(input logic e, input logic v, input logic g, input logic [DW-1:0] a,
                      input logic [DW-1:0] b, input logic [DW-1:0] c);
    en = e; in_valid = v; in_edge = g; r0 = a; r1 = b; r2 = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic ev, input logic ee, input logic [DW-1:0] ep);
    chk({nm, " valid"}, 32'(pix_out_valid), 32'(ev));
    chk({nm, " edge"}, 32'(pix_out_edge), 32'(ee));
    chk({nm, " pix"}, 32'(pix_out), 32'(ep));
  endtask

  initial begin
    int vcnt;
    int ecnt;
    // constant image: zero gradient, first output 2 clks after the 3rd accept
    tbl[0]  = mk(1'b1, 1'b1, 1'b1, K8, K8, K8, 1'b0, 1'b0, Z);
    tbl[1]  = mk(1'b1, 1'b1, 1'b0, K8, K8, K8, 1'b0, 1'b0, Z);
    tbl[2]  = mk(1'b1, 1'b1, 1'b0, K8, K8, K8, 1'b0, 1'b0, Z);
    tbl[3]  = mk(1'b1, 1'b1, 1'b0, K8, K8, K8, 1'b0, 1'b0, Z);
    tbl[4]  = mk(1'b1, 1'b1, 1'b0, K8, K8, K8, 1'b1, 1'b1, Z);
    tbl[5]  = mk(1'b1, 1'b1, 1'b0, K8, K8, K8, 1'b1, 1'b0, Z);
    // vertical rising step: Gx = 16380, saturates
    tbl[6]  = mk(1'b1, 1'b1, 1'b1, Z, Z, Z, 1'b1, 1'b0, Z);
    tbl[7]  = mk(1'b1, 1'b1, 1'b0, Z, Z, Z, 1'b1, 1'b0, Z);
    tbl[8]  = mk(1'b1, 1'b1, 1'b0, KF, KF, KF, 1'b0, 1'b0, Z);
    tbl[9]  = mk(1'b1, 1'b1, 1'b0, KF, KF, KF, 1'b0, 1'b0, Z);
    tbl[10] = mk(1'b1, 1'b1, 1'b0, KF, KF, KF, 1'b1, 1'b1, xf(KF));
    tbl[11] = mk(1'b0, 1'b0, 1'b0, KF, KF, KF, 1'b1, 1'b0, xf(KF));
    tbl[12] = mk(1'b1, 1'b0, 1'b0, KF, KF, KF, 1'b1, 1'b0, Z);
    tbl[13] = mk(1'b0, 1'b1, 1'b0, KF, KF, KF, 1'b0, 1'b0, Z);
    tbl[14] = mk(1'b1, 1'b0, 1'b0, KF, KF, KF, 1'b0, 1'b0, Z);
    // top row 0, middle/bottom 10: Gy = 40, with in_valid toggling
    tbl[15] = mk(1'b1, 1'b1, 1'b1, T, T, Z, 1'b0, 1'b0, Z);
    tbl[16] = mk(1'b1, 1'b1, 1'b0, T, T, Z, 1'b0, 1'b0, Z);
    tbl[17] = mk(1'b1, 1'b1, 1'b0, T, T, Z, 1'b0, 1'b0, Z);
    tbl[18] = mk(1'b1, 1'b0, 1'b0, T, T, Z, 1'b0, 1'b0, Z);
    tbl[19] = mk(1'b1, 1'b1, 1'b0, T, T, Z, 1'b1, 1'b1, xf(M40));
    tbl[20] = mk(1'b1, 1'b0, 1'b0, T, T, Z, 1'b0, 1'b0, xf(M40));
    tbl[21] = mk(1'b1, 1'b1, 1'b0, T, T, Z, 1'b1, 1'b0, xf(M40));
    tbl[22] = mk(1'b1, 1'b0, 1'b0, T, T, Z, 1'b0, 1'b0, xf(M40));
    tbl[23] = mk(1'b0, 1'b0, 1'b0, T, T, Z, 1'b1, 1'b0, xf(M40));
    tbl[24] = mk(1'b0, 1'b0, 1'b0, T, T, Z, 1'b0, 1'b0, xf(M40));
    // falling step: Gx = -16380, magnitude still saturates
    tbl[25] = mk(1'b1, 1'b1, 1'b1, KF, KF, KF, 1'b0, 1'b0, xf(M40));
    tbl[26] = mk(1'b1, 1'b1, 1'b0, KF, KF, KF, 1'b0, 1'b0, xf(M40));
    tbl[27] = mk(1'b1, 1'b1, 1'b0, Z, Z, Z, 1'b0, 1'b0, xf(M40));
    tbl[28] = mk(1'b1, 1'b1, 1'b0, Z, Z, Z, 1'b0, 1'b0, xf(M40));
    tbl[29] = mk(1'b0, 1'b0, 1'b0, Z, Z, Z, 1'b1, 1'b1, xf(KF));
    tbl[30] = mk(1'b0, 1'b0, 1'b0, Z, Z, Z, 1'b1, 1'b0, xf(KF));
    tbl[31] = mk(1'b0, 1'b0, 1'b0, Z, Z, Z, 1'b0, 1'b0, xf(KF));
    // mixed window: Gx = 24, Gy = -8, mag = 32
    tbl[32] = mk(1'b1, 1'b1, 1'b1, 12'd1, 12'd2, 12'd3, 1'b0, 1'b0, xf(KF));
    tbl[33] = mk(1'b1, 1'b1, 1'b0, 12'd4, 12'd5, 12'd6, 1'b0, 1'b0, xf(KF));
    tbl[34] = mk(1'b1, 1'b1, 1'b0, 12'd7, 12'd8, 12'd9, 1'b0, 1'b0, xf(KF));
    tbl[35] = mk(1'b0, 1'b0, 1'b0, 12'd7, 12'd8, 12'd9, 1'b0, 1'b0, xf(KF));
    tbl[36] = mk(1'b0, 1'b0, 1'b0, 12'd7, 12'd8, 12'd9, 1'b1, 1'b1, xf(M32));
    tbl[37] = mk(1'b0, 1'b0, 1'b0, 12'd7, 12'd8, 12'd9, 1'b0, 1'b0, xf(M32));

    // reset state
    @(posedge clk); #1;
    chk_out("reset", 1'b0, 1'b0, Z);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      step(tbl[i].en, tbl[i].vld, tbl[i].edg, tbl[i].r0, tbl[i].r1, tbl[i].r2);
      chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ee, tbl[i].ep);
    end

    // long line: column counter saturates, no bubbles, exactly one edge pulse
    vcnt = 0; ecnt = 0;
    for (int i = 0; i < 1102; i++) begin
      if (i < 1100) step(1'b1, 1'b1, (i == 0), T, T, Z);
      else step(1'b0, 1'b0, 1'b0, T, T, Z);
      if (pix_out_valid) vcnt++;
      if (pix_out_edge) ecnt++;
    end
    chk("long valid count", 32'(vcnt), 32'd1098);
    chk("long edge count", 32'(ecnt), 32'd1);
    chk("long pix", 32'(pix_out), 32'(xf(M40)));

    // in_edge reasserted mid-line at column 50
    for (int i = 0; i < 50; i++) step(1'b1, 1'b1, (i == 0), T, T, Z);
    step(1'b1, 1'b1, 1'b1, K8, K8, K8);
    chk_out("midedge a", 1'b1, 1'b0, xf(M40));
    step(1'b1, 1'b1, 1'b0, K8, K8, K8);
    chk_out("midedge b", 1'b1, 1'b0, xf(M40));
    step(1'b1, 1'b1, 1'b0, K8, K8, K8);
    chk_out("midedge c", 1'b0, 1'b0, xf(M40));
    step(1'b0, 1'b0, 1'b0, K8, K8, K8);
    chk_out("midedge d", 1'b0, 1'b0, xf(M40));
    step(1'b0, 1'b0, 1'b0, K8, K8, K8);
    chk_out("midedge first", 1'b1, 1'b1, Z);
    step(1'b0, 1'b0, 1'b0, K8, K8, K8);
    chk("midedge single", 32'(pix_out_valid), 32'd0);

    // reset mid-line at column 100
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1, (i == 0), T, T, Z);
    chk_out("pre-reset", 1'b1, 1'b0, xf(M40));
    en = 1'b0; in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk_out("async reset", 1'b0, 1'b0, Z);
    @(negedge clk);
    rst = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 7; i++) begin
      if (i < 5) step(1'b1, 1'b1, 1'b0, T, T, Z);
      else step(1'b0, 1'b0, 1'b0, T, T, Z);
      if (pix_out_valid) vcnt++;
    end
    chk("post-reset no line", 32'(vcnt), 32'd0);
    step(1'b1, 1'b1, 1'b1, T, T, Z);
    chk_out("post-reset acc1", 1'b0, 1'b0, Z);
    step(1'b1, 1'b1, 1'b0, T, T, Z);
    chk_out("post-reset acc2", 1'b0, 1'b0, Z);
    step(1'b1, 1'b1, 1'b0, T, T, Z);
    chk_out("post-reset acc3", 1'b0, 1'b0, Z);
    step(1'b0, 1'b0, 1'b0, T, T, Z);
    chk_out("post-reset +1", 1'b0, 1'b0, Z);
    step(1'b0, 1'b0, 1'b0, T, T, Z);
    chk_out("post-reset +2", 1'b1, 1'b1, xf(M40));

`ifdef SOBEL_THRESH_EN
    thresh = 12'd50;
    step(1'b1, 1'b1, 1'b1, T, T, Z);
    step(1'b1, 1'b1, 1'b0, T, T, Z);
    step(1'b1, 1'b1, 1'b0, T, T, Z);
    step(1'b0, 1'b0, 1'b0, T, T, Z);
    step(1'b0, 1'b0, 1'b0, T, T, Z);
    chk_out("thresh 50", 1'b1, 1'b1, Z);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
